// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: issue/sequencing stage in front of the pipelined HI/LO multiplier.
// Starts multiplies, performs MTHI/MTLO writes, runs a 32-step restoring divider
// and writes its remainder/quotient into HI/LO, stalling execute while results are pending.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_IDLE     | accepting ops; MT writes and MF reads serviced here
// S_MUL_WAIT | multiply in flight; counter reaches 0 on the HI/LO write edge
// S_DIV_RUN  | one restoring divide step per clock, 32 steps
// S_WB_HI    | write sign-corrected remainder into HI
// S_WB_LO    | write sign-corrected quotient into LO
module muldiv_ctrl #(
    parameter int MUL_LAT = 4
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [2:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        mf_req,
    input  logic        mf_hi,
    output logic [31:0] mf_data,
    output logic        stall,
    output logic [31:0] mul_A,
    output logic [31:0] mul_B,
    output logic        mul_start,
    output logic        mul_sign,
    output logic [1:0]  mul_we,
    input  logic [31:0] mul_HI,
    input  logic [31:0] mul_LO
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_WAIT,
        S_DIV_RUN,
        S_WB_HI,
        S_WB_LO
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] dvd_q, dvd_d;      // dividend magnitude, becomes the quotient as it shifts
    logic [31:0] dvs_q, dvs_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;

    logic        op_active;
    logic        div_signed;
    logic [31:0] rs_mag, rt_mag;
    logic [33:0] rem_shift, rem_diff;

    // Operand magnitudes and the current restoring-divide step
    always_comb begin
        div_signed = (op == OP_DIV);
        rs_mag     = (div_signed && rs[31]) ? -rs : rs;
        rt_mag     = (div_signed && rt[31]) ? -rt : rt;
        rem_shift  = {rem_q, dvd_q[31]};
        rem_diff   = rem_shift - {2'b00, dvs_q};
    end

    assign op_active = (op != 3'd0) && (op != 3'd7);
    assign stall     = Reset_n && (op_active || mf_req) && (state_q != S_IDLE);
    assign mf_data   = mf_hi ? mul_HI : mul_LO;

    // State and divider register update with synchronous active-low reset
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    // Next-state, divider datapath and multiplier port drive
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        mul_start = 1'b0;
        mul_we    = 2'b00;
        mul_sign  = 1'b0;
        mul_A     = rs;
        mul_B     = rt;

        case (state_q)
            S_IDLE: begin
                case (op)
                    OP_MULT, OP_MULTU: begin
                        mul_start = 1'b1;
                        mul_sign  = (op == OP_MULT);
                        cnt_d     = 6'(MUL_LAT);
                        state_d   = S_MUL_WAIT;
                    end
                    OP_MTHI: mul_we = 2'b10;
                    OP_MTLO: mul_we = 2'b01;
                    OP_DIV, OP_DIVU: begin
                        dvd_d     = rs_mag;
                        dvs_d     = rt_mag;
                        neg_quo_d = div_signed & (rs[31] ^ rt[31]);
                        neg_rem_d = div_signed & rs[31];
                        rem_d     = '0;
                        cnt_d     = '0;
                        state_d   = S_DIV_RUN;
                    end
                    default: ;
                endcase
            end
            S_MUL_WAIT: begin
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) state_d = S_IDLE;
            end
            S_DIV_RUN: begin
                rem_d = rem_diff[33] ? rem_shift[32:0] : rem_diff[32:0];
                dvd_d = {dvd_q[30:0], ~rem_diff[33]};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) state_d = S_WB_HI;
            end
            S_WB_HI: begin
                mul_we  = 2'b10;
                mul_A   = neg_rem_q ? -rem_q[31:0] : rem_q[31:0];
                state_d = S_WB_LO;
            end
            S_WB_LO: begin
                mul_we  = 2'b01;
                mul_A   = neg_quo_q ? -dvd_q : dvd_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Keep the multiplier quiet while reset is held
        if (!Reset_n) begin
            mul_start = 1'b0;
            mul_we    = 2'b00;
            mul_sign  = 1'b0;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with a behavioural 4-stage HI/LO multiplier.
module tb_muldiv_ctrl;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [2:0]  op;
    logic [31:0] rs, rt;
    logic        mf_req, mf_hi;
    logic [31:0] mf_data, mul_A, mul_B;
    logic        stall, mul_start, mul_sign;
    logic [1:0]  mul_we;
    logic [31:0] mul_HI, mul_LO;

    int n_assert = 0;
    int n_fail   = 0;
    int we_pulses = 0;

    // Multiplier model: product lands in HI/LO 4 edges after the start edge
    logic [63:0] m_prod;
    int          m_cnt = 0;

    initial begin
        mul_HI = '0;
        mul_LO = '0;
    end

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (mul_we != 2'b00) we_pulses++;
        if (mul_we[1]) mul_HI <= mul_A;
        if (mul_we[0]) mul_LO <= mul_A;
        if (mul_start) begin
            if (mul_sign) m_prod = {{32{mul_A[31]}}, mul_A} * {{32{mul_B[31]}}, mul_B};
            else          m_prod = {32'd0, mul_A} * {32'd0, mul_B};
            m_cnt = 4;
        end else if (m_cnt != 0) begin
            if (m_cnt == 1) begin
                mul_HI <= m_prod[63:32];
                mul_LO <= m_prod[31:0];
            end
            m_cnt = m_cnt - 1;
        end
    end

    muldiv_ctrl #(.MUL_LAT(4)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .op        (op),
        .rs        (rs),
        .rt        (rt),
        .mf_req    (mf_req),
        .mf_hi     (mf_hi),
        .mf_data   (mf_data),
        .stall     (stall),
        .mul_A     (mul_A),
        .mul_B     (mul_B),
        .mul_start (mul_start),
        .mul_sign  (mul_sign),
        .mul_we    (mul_we),
        .mul_HI    (mul_HI),
        .mul_LO    (mul_LO)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic run_div(input string tag, input logic [2:0] dop, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int good;
        op = dop; rs = a; rt = b; mf_req = 1'b1; mf_hi = 1'b1;
        #1;
        chk({tag, " accept stall"}, {31'd0, stall}, 32'd0);
        step();                                   // E0
        op = 3'd0;
        good = 0;
        for (int c = 0; c < 32; c++) begin
            #1;
            if (stall === 1'b1 && mul_we === 2'b00) good++;
            step();
        end
        chk({tag, " run cycles"}, good, 32);
        #1;                                       // cycle ending at E33
        chk({tag, " hi we"}, {30'd0, mul_we}, 32'd2);
        chk({tag, " hi data"}, mul_A, exp_hi);
        chk({tag, " hi stall"}, {31'd0, stall}, 32'd1);
        step();
        #1;                                       // cycle ending at E34
        chk({tag, " lo we"}, {30'd0, mul_we}, 32'd1);
        chk({tag, " lo data"}, mul_A, exp_lo);
        chk({tag, " lo stall"}, {31'd0, stall}, 32'd1);
        step();
        #1;                                       // after E34
        chk({tag, " post stall"}, {31'd0, stall}, 32'd0);
        chk({tag, " MFHI"}, mf_data, exp_hi);
        mf_hi = 1'b0;
        #1;
        chk({tag, " MFLO"}, mf_data, exp_lo);
        mf_req = 1'b0;
    endtask

    initial begin
        int good;
        Reset_n = 1'b0; op = 3'd0; rs = '0; rt = '0; mf_req = 1'b1; mf_hi = 1'b0;
        step();
        step();
        chk("rst stall", {31'd0, stall}, 32'd0);
        chk("rst start", {31'd0, mul_start}, 32'd0);
        chk("rst we", {30'd0, mul_we}, 32'd0);
        chk("rst sign", {31'd0, mul_sign}, 32'd0);
        Reset_n = 1'b1; mf_req = 1'b0;
        step();

        // MTHI then MFHI
        op = 3'd5; rs = 32'h12345678;
        #1;
        chk("mthi we", {30'd0, mul_we}, 32'd2);
        chk("mthi data", mul_A, 32'h12345678);
        step();
        op = 3'd0; rs = '0; mf_req = 1'b1; mf_hi = 1'b1;
        #1;
        chk("mfhi stall", {31'd0, stall}, 32'd0);
        chk("mfhi data", mf_data, 32'h12345678);
        // MTLO then MFLO
        op = 3'd6; rs = 32'hCAFEBABE; mf_req = 1'b0;
        #1;
        chk("mtlo we", {30'd0, mul_we}, 32'd1);
        step();
        op = 3'd0; rs = '0; mf_req = 1'b1; mf_hi = 1'b0;
        #1;
        chk("mflo stall", {31'd0, stall}, 32'd0);
        chk("mflo data", mf_data, 32'hCAFEBABE);
        mf_req = 1'b0;
        step();

        // MULT -3 * 5
        op = 3'd1; rs = 32'hFFFFFFFD; rt = 32'd5;
        #1;
        chk("mult start", {31'd0, mul_start}, 32'd1);
        chk("mult sign", {31'd0, mul_sign}, 32'd1);
        chk("mult A", mul_A, 32'hFFFFFFFD);
        chk("mult B", mul_B, 32'd5);
        step();                                   // E0
        op = 3'd0;
        #1;
        chk("mult start once", {31'd0, mul_start}, 32'd0);
        step();                                   // E1
        mf_req = 1'b1; mf_hi = 1'b1;
        good = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (stall === 1'b1 && mul_start === 1'b0) good++;
            step();
        end
        chk("mult stall cycles", good, 3);
        #1;                                       // after E4
        chk("mult post stall", {31'd0, stall}, 32'd0);
        chk("mult MFHI", mf_data, 32'hFFFFFFFF);
        mf_hi = 1'b0;
        #1;
        chk("mult MFLO", mf_data, 32'hFFFFFFF1);
        mf_req = 1'b0;
        step();

        run_div("div -7/2", 3'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        step();
        run_div("divu 10/0", 3'd4, 32'd10, 32'd0, 32'h0000000A, 32'hFFFFFFFF);
        step();
        run_div("div min/-1", 3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        step();

        // DIVU interrupted by reset sampled at E10
        op = 3'd4; rs = 32'd100; rt = 32'd7;
        step();                                   // E0
        op = 3'd0; mf_req = 1'b1;
        for (int c = 0; c < 9; c++) step();       // after E9
        Reset_n = 1'b0;
        step();                                   // E10
        Reset_n = 1'b1;
        we_pulses = 0;
        #1;
        chk("rst mid stall", {31'd0, stall}, 32'd0);
        chk("rst mid we", {30'd0, mul_we}, 32'd0);
        for (int c = 0; c < 40; c++) step();
        chk("rst mid no we", we_pulses, 0);

        // MULTU 3*4 with a same-cycle MFLO returning the pre-op LO
        op = 3'd2; rs = 32'd3; rt = 32'd4; mf_req = 1'b1; mf_hi = 1'b0;
        #1;
        chk("multu accept stall", {31'd0, stall}, 32'd0);
        chk("multu sign", {31'd0, mul_sign}, 32'd0);
        chk("multu pre-op LO", mf_data, 32'h80000000);
        step();                                   // E0
        op = 3'd0; mf_req = 1'b0;
        for (int c = 0; c < 4; c++) step();       // after E4
        mf_req = 1'b1; mf_hi = 1'b0;
        #1;
        chk("multu stall", {31'd0, stall}, 32'd0);
        chk("multu LO", mf_data, 32'd12);
        mf_hi = 1'b1;
        #1;
        chk("multu HI", mf_data, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
